// File: rtl/scsi_fifo_packer.sv
// Packs received SCSI bytes big-endian into 32-bit FIFO longwords, with flush of partial words.
// Optional odd-parity checking on accepted bytes is enabled by defining SCSI_PARITY_EN.
module scsi_fifo_packer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        S2F,
  input  logic        BYTE_VALID,
  input  logic [7:0]  SCSI_DATA_IN,
  input  logic        SCSI_DP,
  input  logic        FLUSH,
  input  logic        FIFO_FULL,
  output logic        BYTE_READY,
  output logic        FIFO_WE,
  output logic [31:0] FIFO_ID,
  output logic [3:0]  FIFO_BE,
  output logic        FLUSH_DONE,
  output logic        PERR
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] asm_reg, asm_next;
  logic [31:0] hold_reg, hold_next;
  logic [3:0]  hold_be_reg, hold_be_next;
  logic        hold_valid_reg, hold_valid_next;
  logic        accept;
  logic        hold_free;

  // The hold slot is free either when empty or when it is being written out on this edge.
  assign hold_free = ~hold_valid_reg | FIFO_WE;
  assign accept    = S2F & BYTE_VALID & BYTE_READY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_FILL;
      cnt_reg        <= 2'd0;
      asm_reg        <= 32'd0;
      hold_reg       <= 32'd0;
      hold_be_reg    <= 4'd0;
      hold_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      asm_reg        <= asm_next;
      hold_reg       <= hold_next;
      hold_be_reg    <= hold_be_next;
      hold_valid_reg <= hold_valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FILL:  if (FLUSH) state_next = ST_FLUSH;
      ST_FLUSH: if (cnt_reg == 2'd0 && hold_free) state_next = ST_DONE;
      ST_DONE:  state_next = ST_FILL;
      default:  state_next = ST_FILL;
    endcase
  end

  always_comb begin
    cnt_next        = cnt_reg;
    asm_next        = asm_reg;
    hold_next       = hold_reg;
    hold_be_next    = hold_be_reg;
    hold_valid_next = hold_valid_reg & ~FIFO_WE;
    if (accept) begin
      if (cnt_reg == 2'd3) begin
        hold_next       = {asm_reg[31:8], SCSI_DATA_IN};
        hold_be_next    = 4'b1111;
        hold_valid_next = 1'b1;
        asm_next        = 32'd0;
        cnt_next        = 2'd0;
      end else begin
        // Lane (3 - cnt) is the bitwise inverse of the 2-bit counter.
        asm_next[{~cnt_reg, 3'b000} +: 8] = SCSI_DATA_IN;
        cnt_next = cnt_reg + 2'd1;
      end
    end else if (state_reg == ST_FLUSH && cnt_reg != 2'd0 && hold_free) begin
      // Unfilled lanes are already zero because the assembly register is cleared on every move.
      hold_next       = asm_reg;
      hold_valid_next = 1'b1;
      asm_next        = 32'd0;
      cnt_next        = 2'd0;
      case (cnt_reg)
        2'd1:    hold_be_next = 4'b1000;
        2'd2:    hold_be_next = 4'b1100;
        default: hold_be_next = 4'b1110;
      endcase
    end
  end

  always_comb begin
    FIFO_WE    = hold_valid_reg & ~FIFO_FULL;
    BYTE_READY = ~RESET & S2F & (state_reg == ST_FILL) &
                 ~(hold_valid_reg & (cnt_reg == 2'd3) & ~FIFO_WE);
    FLUSH_DONE = (state_reg == ST_DONE);
    FIFO_ID    = hold_reg;
    FIFO_BE    = hold_be_reg;
  end

`ifdef SCSI_PARITY_EN
  logic perr_reg;

  // Odd parity over {DP, data}: an even XOR reduction marks a bad byte.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      perr_reg <= 1'b0;
    else if (accept && !(^{SCSI_DP, SCSI_DATA_IN}))
      perr_reg <= 1'b1;
  end

  assign PERR = perr_reg;
`else
  logic unused_dp;
  assign unused_dp = SCSI_DP;
  assign PERR      = 1'b0;
`endif

endmodule

// File: tb/tb_scsi_fifo_packer.sv
// Directed-vector bench for scsi_fifo_packer; expected values are hand-computed constants.
// Parity expectations follow whether SCSI_PARITY_EN is defined for the build.
module tb_scsi_fifo_packer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        S2F;
  logic        BYTE_VALID;
  logic [7:0]  SCSI_DATA_IN;
  logic        SCSI_DP;
  logic        FLUSH;
  logic        FIFO_FULL;
  logic        BYTE_READY;
  logic        FIFO_WE;
  logic [31:0] FIFO_ID;
  logic [3:0]  FIFO_BE;
  logic        FLUSH_DONE;
  logic        PERR;

  int vectors = 0;
  int miscompares = 0;
  int wr_count = 0;
  int wr_base;
  logic [31:0] wr_id_q[$];
  logic [3:0]  wr_be_q[$];
  logic        perr_exp;

  always #5 CLK = ~CLK;

  scsi_fifo_packer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .S2F          (S2F),
    .BYTE_VALID   (BYTE_VALID),
    .SCSI_DATA_IN (SCSI_DATA_IN),
    .SCSI_DP      (SCSI_DP),
    .FLUSH        (FLUSH),
    .FIFO_FULL    (FIFO_FULL),
    .BYTE_READY   (BYTE_READY),
    .FIFO_WE      (FIFO_WE),
    .FIFO_ID      (FIFO_ID),
    .FIFO_BE      (FIFO_BE),
    .FLUSH_DONE   (FLUSH_DONE),
    .PERR         (PERR)
  );

  // FIFO-side monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (FIFO_WE === 1'b1) begin
      wr_id_q.push_back(FIFO_ID);
      wr_be_q.push_back(FIFO_BE);
      wr_count++;
      $display("fifo write %0d: id=%08h be=%04b", wr_count, FIFO_ID, FIFO_BE);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic offer_dp(input logic [7:0] d, input logic dp);
    BYTE_VALID   = 1'b1;
    SCSI_DATA_IN = d;
    SCSI_DP      = dp;
    tick();
  endtask

  // Good byte: DP makes the 9-bit parity odd.
  task automatic offer(input logic [7:0] d);
    offer_dp(d, ~(^d));
  endtask

  initial begin
    RESET = 1'b1; S2F = 1'b1; BYTE_VALID = 1'b0; SCSI_DATA_IN = 8'h00;
    SCSI_DP = 1'b0; FLUSH = 1'b0; FIFO_FULL = 1'b0;
    #3;
    check("rst_byte_ready", {31'd0, BYTE_READY}, 32'd0);
    check("rst_fifo_we",    {31'd0, FIFO_WE},    32'd0);
    check("rst_fifo_id",    FIFO_ID,             32'd0);
    check("rst_fifo_be",    {28'd0, FIFO_BE},    32'd0);
    check("rst_flush_done", {31'd0, FLUSH_DONE}, 32'd0);
    check("rst_perr",       {31'd0, PERR},       32'd0);
    tick(); tick();
    RESET = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, BYTE_READY}, 32'd1);

    // Four back-to-back bytes, one write one cycle after the 4th.
    wr_base = wr_count;
    offer(8'h11); offer(8'h22); offer(8'h33);
    check("no_we_before_4th", {31'd0, FIFO_WE}, 32'd0);
    offer(8'h44);
    BYTE_VALID = 1'b0;
    check("word_we",  {31'd0, FIFO_WE}, 32'd1);
    check("word_id",  FIFO_ID,          32'h11223344);
    check("word_be",  {28'd0, FIFO_BE}, 32'hF);
    tick();
    check("word_we_drop", {31'd0, FIFO_WE}, 32'd0);
    check("word_pulses",  wr_count - wr_base, 32'd1);

    // FIFO full: first word held, 4th byte of second word stalled.
    FIFO_FULL = 1'b1;
    wr_base = wr_count;
    for (int i = 1; i <= 7; i++) offer(i[7:0]);
    BYTE_VALID = 1'b1; SCSI_DATA_IN = 8'h08; SCSI_DP = ~(^SCSI_DATA_IN);
    #1;
    check("full_ready_low", {31'd0, BYTE_READY}, 32'd0);
    tick(); tick(); tick();
    check("full_still_low", {31'd0, BYTE_READY}, 32'd0);
    check("full_no_we",     {31'd0, FIFO_WE},    32'd0);
    check("full_held_id",   FIFO_ID,             32'h01020304);
    FIFO_FULL = 1'b0;
    #1;
    check("release_we",    {31'd0, FIFO_WE},    32'd1);
    check("release_ready", {31'd0, BYTE_READY}, 32'd1);
    tick();
    BYTE_VALID = 1'b0;
    check("second_we", {31'd0, FIFO_WE}, 32'd1);
    check("second_id", FIFO_ID,          32'h05060708);
    tick();
    check("second_we_drop", {31'd0, FIFO_WE}, 32'd0);
    check("full_pulses", wr_count - wr_base, 32'd2);
    if (wr_count >= 2) begin
      check("full_first_logged",  wr_id_q[wr_count-2], 32'h01020304);
      check("full_second_logged", wr_id_q[wr_count-1], 32'h05060708);
    end

    // Two bytes then flush.
    wr_base = wr_count;
    offer(8'hAA); offer(8'hBB);
    BYTE_VALID = 1'b0;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush_ready_low", {31'd0, BYTE_READY}, 32'd0);
    check("flush_no_we_yet", {31'd0, FIFO_WE},    32'd0);
    tick();
    check("flush2_we",   {31'd0, FIFO_WE},    32'd1);
    check("flush2_id",   FIFO_ID,             32'hAABB0000);
    check("flush2_be",   {28'd0, FIFO_BE},    32'hC);
    check("flush2_done_early", {31'd0, FLUSH_DONE}, 32'd0);
    tick();
    check("flush2_done", {31'd0, FLUSH_DONE}, 32'd1);
    check("flush2_we_off", {31'd0, FIFO_WE},  32'd0);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("flush2_done_pulse", {31'd0, FLUSH_DONE}, 32'd0);
    check("flush_ignored_ready", {31'd0, BYTE_READY}, 32'd1);
    check("flush2_pulses", wr_count - wr_base, 32'd1);

    // Third byte accepted on the same edge as FLUSH is included.
    offer(8'h01); offer(8'h02);
    FLUSH = 1'b1;
    offer(8'h03);
    FLUSH = 1'b0;
    BYTE_VALID = 1'b0;
    tick();
    check("flush3_id", FIFO_ID,          32'h01020300);
    check("flush3_be", {28'd0, FIFO_BE}, 32'hE);
    tick();
    check("flush3_done", {31'd0, FLUSH_DONE}, 32'd1);
    tick();

    // Flush with nothing pending: FLUSH_DONE after two edges, no write.
    wr_base = wr_count;
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    check("empty_flush_edge1", {31'd0, FLUSH_DONE}, 32'd0);
    tick();
    check("empty_flush_done", {31'd0, FLUSH_DONE}, 32'd1);
    tick();
    check("empty_flush_clear", {31'd0, FLUSH_DONE}, 32'd0);
    check("empty_flush_no_we", wr_count - wr_base, 32'd0);

    // Reset mid-word discards the partial data.
    offer(8'h55); offer(8'h66); offer(8'h77);
    BYTE_VALID = 1'b0;
    RESET = 1'b1;
    #1;
    check("midrst_ready", {31'd0, BYTE_READY}, 32'd0);
    check("midrst_we",    {31'd0, FIFO_WE},    32'd0);
    check("midrst_id",    FIFO_ID,             32'd0);
    check("midrst_be",    {28'd0, FIFO_BE},    32'd0);
    tick();
    RESET = 1'b0;
    offer(8'h12); offer(8'h34); offer(8'h56); offer(8'h78);
    BYTE_VALID = 1'b0;
    check("after_rst_we", {31'd0, FIFO_WE}, 32'd1);
    check("after_rst_id", FIFO_ID,          32'h12345678);
    tick();

    // Bad parity on 8'h01 with DP=1.
`ifdef SCSI_PARITY_EN
    perr_exp = 1'b1;
`else
    perr_exp = 1'b0;
`endif
    check("perr_before", {31'd0, PERR}, 32'd0);
    offer_dp(8'h01, 1'b1);
    check("perr_set", {31'd0, PERR}, {31'd0, perr_exp});
    offer(8'h02); offer(8'h03); offer(8'h04);
    BYTE_VALID = 1'b0;
    check("perr_word_id", FIFO_ID,         32'h01020304);
    check("perr_word_we", {31'd0, FIFO_WE}, 32'd1);
    tick(); tick();
    check("perr_sticky", {31'd0, PERR}, {31'd0, perr_exp});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
